pipo_shift_reg: RTL and testbench

//   Parallel-in/parallel-out register with a serial shift-right mode.

---
 rtl/pipo_shift_reg_pkg.sv | 24 ++
 rtl/pipo_shift_reg.sv | 32 +++
 tb/tb_pipo_shift_reg.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pipo_shift_reg_pkg.sv
// Shared definitions for the parallel-in/parallel-out shift register.
package pipo_shift_reg_pkg;

  // Update applied to the register at a clock edge
  typedef enum logic [1:0] {
    MODE_CLEAR = 2'd0,
    MODE_LOAD  = 2'd1,
    MODE_SHIFT = 2'd2
  } mode_t;

  // Reset wins over load; load wins over shift.
  function automatic mode_t sel_mode(input logic rst_n, input logic l_en);
    mode_t m;
    if (!rst_n) begin
      m = MODE_CLEAR;
    end else if (l_en) begin
      m = MODE_LOAD;
    end else begin
      m = MODE_SHIFT;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipo_shift_reg.sv
// Parallel-in/parallel-out register with a serial shift-right mode.
// Each edge either clears, loads p_in, or shifts s_in_sr in at the MSB.
module pipo_shift_reg
  import pipo_shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             l_en,
  input  logic             s_in_sr,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] p_out
);

  mode_t            mode;
  logic [WIDTH-1:0] shifted;

  assign mode    = sel_mode(rst_n, l_en);
  // Shift right: serial bit enters at the MSB, LSB is discarded
  assign shifted = {s_in_sr, p_out[WIDTH-1:1]};

  // Register update; synchronous active-low clear has top priority
  always_ff @(posedge clk) begin
    case (mode)
      MODE_CLEAR: p_out <= '0;
      MODE_LOAD:  p_out <= p_in;
      default:    p_out <= shifted;
    endcase
  end

endmodule

// File: tb/tb_pipo_shift_reg.sv
// Scoreboard bench for pipo_shift_reg: stimulus pushes expected words,
// a monitor pops and compares one after every rising edge.
module tb_pipo_shift_reg;

  localparam int unsigned W = 4;

  typedef struct {
    logic [W-1:0] val;
    string        name;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         l_en;
  logic         s_in_sr;
  logic [W-1:0] p_in;
  logic [W-1:0] p_out;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   model  = 0;

  pipo_shift_reg #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .l_en    (l_en),
    .s_in_sr (s_in_sr),
    .p_in    (p_in),
    .p_out   (p_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one edge's inputs and push the value the register must hold after it
  task automatic step(input logic r, input logic l, input logic s,
                      input logic [W-1:0] p, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n   = r;
    l_en    = l;
    s_in_sr = s;
    p_in    = p;
    if (!r) begin
      model = 0;
    end else if (l) begin
      model = int'(p);
    end else begin
      model = model / 2 + (s ? (1 << (W - 1)) : 0);
    end
    e.val  = model[W-1:0];
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: the register presents a new word after every edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (p_out !== e.val) begin
          fails++;
          $display("FAIL %s: p_out=%b expected=%b at %0t", e.name, p_out, e.val, $time);
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    l_en    = 1'b1;
    s_in_sr = 1'b0;
    p_in    = '1;

    // Reset held for two edges while load is requested
    step(0, 1, 0, 4'b1111, "reset1");
    step(0, 1, 0, 4'b1111, "reset2");

    // Parallel loads
    step(1, 1, 0, 4'b1010, "load_1010");
    step(1, 1, 0, 4'b1111, "load_1111");
    step(1, 1, 0, 4'b0000, "load_0000");

    // Load then shift 1,0,1,0
    step(1, 1, 0, 4'b1100, "load_1100");
    step(1, 0, 1, 4'b0000, "shift_a1");
    step(1, 0, 0, 4'b1111, "shift_a2");
    step(1, 0, 1, 4'b0000, "shift_a3");
    step(1, 0, 0, 4'b1111, "shift_a4");

    // Shift after reset, then four 1s
    step(0, 0, 1, 4'b1111, "reset_mid");
    step(1, 0, 1, 4'b0000, "shift_b1");
    step(1, 0, 0, 4'b0000, "shift_b2");
    step(1, 0, 1, 4'b0000, "shift_b3");
    step(1, 0, 0, 4'b0000, "shift_b4");
    for (int i = 0; i < 4; i++) step(1, 0, 1, 4'b0000, "shift_ones");

    // Mode toggling
    step(1, 1, 0, 4'b1010, "tog_load_1010");
    step(1, 0, 0, 4'b1111, "tog_shift0");
    step(1, 1, 1, 4'b0101, "tog_load_0101");
    step(1, 1, 0, 4'b0011, "tog_load_0011");
    step(1, 0, 1, 4'b0000, "tog_shift1a");
    step(1, 0, 1, 4'b1111, "tog_shift1b");

    // Reset priority over load, then release with load active
    step(0, 1, 1, 4'b1111, "rst_over_load");
    step(1, 1, 0, 4'b1111, "release_load");

    // Randomized traffic, occasional reset pulses
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom),
           W'($urandom), "random");
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
